// File: rtl/arbiter_rr_param.sv
// ---------------------------------------------------------------------------
// arbiter_rr_param
// Round-robin arbiter for N requesters with registered one-hot grant.
//
// A rotating pointer sets the search start. A granted requester keeps its
// grant while it still requests and its hold has not expired. On release or
// expiry the arbiter re-arbitrates in the same cycle, so there is no idle gap.
//
// Build option: define ARB_LOCK_EN to enable grant locking. A hold counter
// then lets a requester keep the grant for up to MAX_HOLD consecutive cycles.
// With ARB_LOCK_EN undefined there is no counter, and every GRANT cycle is
// treated as expired, so the grant rotates each cycle among active
// requesters. Ports and reset values are the same in both builds.
//
// Handshake: none. req is level-sensitive and sampled on every rising edge.
// grant, grant_valid and grant_idx are registered and change only on a
// rising edge. grant_valid is high exactly when grant is nonzero, and
// grant_idx is 0 whenever grant_valid is low.
// ---------------------------------------------------------------------------
module arbiter_rr_param #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int              IW       = $clog2(N);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);
    localparam logic [IW:0]     N_EXT    = (IW + 1)'(N);

    // Parameters outside the supported range stop elaboration.
    if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
        $error("arbiter_rr_param: N must be 2..16 and MAX_HOLD 1..255");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic            r_valid;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_ptr;

    state_t          w_state_nxt;
    logic [N-1:0]    w_grant_nxt;
    logic            w_valid_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_load;
    logic            w_expired;
    logic            w_hold_ok;

    logic [2*N-1:0]  w_rot;
    logic            w_found;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_pick;
    logic [N-1:0]    w_pick_oh;

    // Rotate req so that bit 0 of w_rot is the requester at ptr. The lowest
    // set bit is then the first requester in search order.
    always_comb begin
        w_rot   = {req, req} >> r_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= N_EXT) begin
            w_pick = IW'(w_sum - N_EXT);
        end else begin
            w_pick = w_sum[IW-1:0];
        end
        w_pick_oh = {{(N-1){1'b0}}, 1'b1} << w_pick;
    end

`ifdef ARB_LOCK_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    logic [7:0] r_hold_cnt;

    assign w_expired = (r_hold_cnt >= HOLD_LIM);

    // Count cycles of the current grant. The count restarts at 1 on every
    // new grant, including a re-grant to the same requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_load) begin
            r_hold_cnt <= 8'd1;
        end else if (r_state == ST_GRANT && w_state_nxt == ST_GRANT) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end else begin
            r_hold_cnt <= '0;
        end
    end
`else
    assign w_expired = 1'b1;
`endif

    // The holder may keep the grant only while it still requests and its
    // hold has not run out.
    assign w_hold_ok = req[r_idx] && !w_expired;

    // Next-state logic: keep the grant, take a new grant, or fall back to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                    w_idx_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!w_hold_ok) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
        if (w_load) begin
            w_state_nxt = ST_GRANT;
            w_grant_nxt = w_pick_oh;
            w_idx_nxt   = w_pick;
            w_ptr_nxt   = (w_pick == LAST_IDX) ? '0 : w_pick + 1'b1;
        end
        w_valid_nxt = |w_grant_nxt;
    end

    // State, pointer and registered outputs. Reset overrides any active grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_param
// Directed bench for arbiter_rr_param with N=4 and MAX_HOLD=4. Expected
// grants are hand-derived. HOLD is the expected run length of one grant
// under continuous requests: MAX_HOLD with ARB_LOCK_EN, otherwise 1.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_param;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_LOCK_EN
    localparam int HOLD = MAX_HOLD;
`else
    localparam int HOLD = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;

    int n_checks;
    int n_errors;

    arbiter_rr_param #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle 1 time unit past it. Outputs are
    // sampled and inputs are driven at that point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for one edge, then release it with the given request.
    task automatic do_reset(input logic [N-1:0] r);
        rst_n = 1'b0;
        req   = '0;
        step();
        rst_n = 1'b1;
        req   = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_grant cyc%0d: got %b expected 0000", c, grant);
            end
            n_checks++;
            if (grant_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_valid cyc%0d: got %b expected 0", c, grant_valid);
            end
            n_checks++;
            if (grant_idx !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_idx cyc%0d: got %0d expected 0", c, grant_idx);
            end
        end
    endtask

    // req=1111 held after release: each requester 0,1,2,3 in turn for HOLD
    // cycles, then requester 0 again.
    task automatic test_all_held();
        logic [N-1:0] exp_g;
        logic [1:0]   exp_i;
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp_i = 2'(r % N);
            exp_g = 4'b0001 << exp_i;
            for (int h = 0; h < HOLD; h++) begin
                step();
                n_checks++;
                if (grant !== exp_g) begin
                    n_errors++;
                    $display("FAIL all_held_grant r%0d h%0d: got %b expected %b", r, h, grant, exp_g);
                end
                n_checks++;
                if (grant_idx !== exp_i || grant_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL all_held_idx r%0d h%0d: got idx=%0d valid=%b expected idx=%0d valid=1",
                             r, h, grant_idx, grant_valid, exp_i);
                end
            end
        end
    endtask

    // req=0101: requester 0 drops after two granted cycles, and requester 2
    // must follow on the very next edge.
    task automatic test_early_release();
        logic [N-1:0] exp_second;
`ifdef ARB_LOCK_EN
        exp_second = 4'b0001;
`else
        exp_second = 4'b0100;
`endif
        do_reset(4'b0101);
        step();
        n_checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            n_errors++;
            $display("FAIL early_first: got %b idx=%0d expected 0001 idx=0", grant, grant_idx);
        end
        step();
        n_checks++;
        if (grant !== exp_second) begin
            n_errors++;
            $display("FAIL early_second: got %b expected %b", grant, exp_second);
        end
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL early_handoff: got %b valid=%b expected 0100 valid=1", grant, grant_valid);
        end
        n_checks++;
        if (grant_idx !== 2'd2) begin
            n_errors++;
            $display("FAIL early_handoff_idx: got %0d expected 2", grant_idx);
        end
    endtask

    // Lone requester 1 is re-granted at every expiry, with no gap.
    task automatic test_single();
        do_reset(4'b0010);
        for (int c = 0; c < 3 * MAX_HOLD; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0010 || grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
                n_errors++;
                $display("FAIL single cyc%0d: got %b valid=%b idx=%0d expected 0010 valid=1 idx=1",
                         c, grant, grant_valid, grant_idx);
            end
        end
    endtask

    // Return to idle, then reset in the middle of a hold.
    task automatic test_idle_and_mid_reset();
        req = 4'b0000;
        step();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            n_errors++;
            $display("FAIL idle: got %b valid=%b idx=%0d expected 0000 valid=0 idx=0",
                     grant, grant_valid, grant_idx);
        end
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
            n_errors++;
            $display("FAIL idle_regrant: got %b idx=%0d expected 0100 idx=2", grant, grant_idx);
        end
        step();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_errors++;
            $display("FAIL mid_hold: got %b expected 0100", grant);
        end
        rst_n = 1'b0;
        req   = 4'b1111;
        step();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            n_errors++;
            $display("FAIL mid_reset: got %b valid=%b idx=%0d expected 0000 valid=0 idx=0",
                     grant, grant_valid, grant_idx);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_first: got %b idx=%0d valid=%b expected 0001 idx=0 valid=1",
                     grant, grant_idx, grant_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        #1;
        test_reset();
        test_all_held();
        test_early_release();
        test_single();
        test_idle_and_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_param.md
ARBITER_RR_PARAM -- requirements
Module: arbiter_rr_param

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (legal range 2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive cycles one requester may hold a locked grant (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning reset; it is synchronous and active-low.
REQ-005 SHALL have port req, input, N bits, meaning per-requester request, level-sensitive.
REQ-006 SHALL have port grant, output, N bits, meaning the registered grant, one-hot or all-zero.
REQ-007 SHALL have port grant_valid, output, 1 bit, meaning high when grant is nonzero.
REQ-008 SHALL have port grant_idx, output, $clog2(N) bits, meaning the binary index of the granted requester; it is 0 when grant_valid is low.

Function
REQ-009 SHALL register all outputs; a request sampled at edge k produces its grant visible after edge k.
REQ-010 SHALL keep a rotating priority pointer ptr (0..N-1); the search order is ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
REQ-011 SHALL, in state IDLE, with req nonzero, grant the first requester in the search order, set ptr to granted index + 1 (mod N), and move to GRANT.
REQ-012 SHALL, in state IDLE, with req equal to zero, drive grant to 0, leave ptr unchanged, and stay in IDLE.
REQ-013 SHALL, in state GRANT, with the grant holder g still requesting and hold not expired (REQ-020), keep grant unchanged.
REQ-014 SHALL, in state GRANT, when g deasserts req or the hold expires: if any other req bit is set, re-arbitrate in the same cycle (no idle bubble) per REQ-010/011; otherwise return to IDLE with grant 0.
REQ-015 SHALL, on hold expiry with only g requesting, re-grant g (the search wraps back to it) and restart its hold count.
REQ-016 SHALL give no fixed-priority bias: with all N requesting continuously, each requester receives an equal share over any N x MAX_HOLD cycle window.
REQ-017 SHALL never assert more than one grant bit; req bits that are X/0 do not affect ptr.
REQ-018 SHALL compute pointer arithmetic modulo N for non-power-of-two N (e.g. N=3: 2+1 yields 0).

Reset
REQ-019 SHALL, while rst_n=0 at a clock edge, force grant=0, grant_valid=0, grant_idx=0, ptr=0, hold count 0, and state IDLE; reset overrides any in-progress grant, and the first grant after release favours requester 0.

Configuration
REQ-020 SHALL, with macro ARB_LOCK_EN defined, implement grant locking: the hold counter counts cycles of the current grant, and the hold expires when the counter reaches MAX_HOLD.
REQ-021 SHALL, with ARB_LOCK_EN not defined, omit the hold counter and treat every GRANT cycle as expired, so the grant rotates every cycle among active requesters.
REQ-022 SHALL keep ports and reset values identical in both builds.

Verification (N=4, MAX_HOLD=4)
REQ-023 SHALL verify reset: rst_n=0 with req=1111 for 2 cycles -> grant=0000, grant_valid=0, grant_idx=0 throughout.
REQ-024 SHALL verify all requesters held with lock: rst_n released, req=1111 held with ARB_LOCK_EN -> grant 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again.
REQ-025 SHALL verify all requesters held without lock: req=1111 without ARB_LOCK_EN -> grant 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-026 SHALL verify early release and sparse requests: req=0101 and requester 0 drops req after 2 granted cycles -> grant 0100 on the next cycle with no zero cycle, and grant_idx=2.
REQ-027 SHALL verify a single requester: req=0010 only -> grant stays 0010 continuously (re-granted at each expiry), and grant_valid stays 1.
REQ-028 SHALL verify the return to idle and mid-grant reset: req=0000 -> grant=0000 one cycle later; separately, rst_n=0 mid-hold on 0100 -> grant=0000 next edge, and with req=1111 after release the first grant is 0001.
